// File: rtl/clock_pkg.sv
// Shared definitions for the clock's set/adjust path.
//   BTN_PRESSED / BTN_RELEASED : logic levels of the active-low push-buttons
//   DEF_*                      : default debounce and auto-repeat timing, in clk cycles
//   cnt_width()                : bits needed to hold a counter value 0..max_val
//   press_edge / release_edge  : classify a stable-level transition (current vs next)
package clock_pkg;

  localparam logic BTN_PRESSED  = 1'b0;
  localparam logic BTN_RELEASED = 1'b1;

  localparam int DEF_DB_CYCLES     = 4;
  localparam int DEF_REPEAT_DELAY  = 32;
  localparam int DEF_REPEAT_PERIOD = 8;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic logic press_edge(input logic cur_n, input logic nxt_n);
    return (cur_n == BTN_RELEASED) && (nxt_n == BTN_PRESSED);
  endfunction

  function automatic logic release_edge(input logic cur_n, input logic nxt_n);
    return (cur_n == BTN_PRESSED) && (nxt_n == BTN_RELEASED);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: 2-FF synchroniser followed by a debouncer.
// A level change is accepted once the synchronised value has differed from the
// stable level for DB_CYCLES consecutive cycles.
//   clk          in   system clock
//   rst_n        in   async active-low reset (channel comes up released)
//   raw_n        in   raw button, asynchronous, 0 = pressed
//   stable_n     out  debounced level (registered)
//   stable_nxt_n out  level stable_n takes on the next edge; a function of
//                     registers only, so press/release events can be acted on
//                     in the very edge that accepts them
module debounce_channel
  import clock_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic stable_n,
  output logic stable_nxt_n
);

  localparam int CW = cnt_width(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          meta_n;
  logic          sync_n;
  logic [CW-1:0] cnt;
  logic          accept;

  assign accept       = (sync_n != stable_n) && (cnt == CNT_LAST);
  assign stable_nxt_n = accept ? sync_n : stable_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_n   <= BTN_RELEASED;
      sync_n   <= BTN_RELEASED;
      stable_n <= BTN_RELEASED;
      cnt      <= '0;
    end else begin
      meta_n <= raw_n;
      sync_n <= meta_n;
      if (sync_n == stable_n) begin
        cnt <= '0;
      end else if (accept) begin
        stable_n <= sync_n;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the three raw SET/UP/DOWN buttons for second_control.
//   clk         in   system clock
//   rst_n       in   async active-low reset
//   btn_set_n   in   raw SET button, 0 = pressed
//   btn_up_n    in   raw UP button, 0 = pressed
//   btn_down_n  in   raw DOWN button, 0 = pressed
//   set_ena     out  adjust mode, toggled by each SET press
//   up          out  active-low 1-cycle increment pulse with auto-repeat
//   down        out  active-low 1-cycle decrement pulse with auto-repeat
// UP/DOWN only act while set_ena is high and exactly one of them is held.
// A channel starts running on the edge it becomes the sole held button through
// its own press (or the other button's release); a button already held when
// set_ena rises therefore stays silent until pressed again.
module button_conditioner
  import clock_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set_n,
  input  logic btn_up_n,
  input  logic btn_down_n,
  output logic set_ena,
  output logic up,
  output logic down
);

  localparam int HW = cnt_width(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(REPEAT_DELAY - 1);
  // After a repeat pulse, restart this far below HOLD_LAST so the next pulse
  // lands REPEAT_PERIOD cycles later; the counter never exceeds HOLD_LAST.
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic set_cur_n, set_nxt_n;
  logic up_cur_n,  up_nxt_n;
  logic dn_cur_n,  dn_nxt_n;

  debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_db_set (
    .clk(clk), .rst_n(rst_n), .raw_n(btn_set_n),
    .stable_n(set_cur_n), .stable_nxt_n(set_nxt_n)
  );

  debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk(clk), .rst_n(rst_n), .raw_n(btn_up_n),
    .stable_n(up_cur_n), .stable_nxt_n(up_nxt_n)
  );

  debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
    .clk(clk), .rst_n(rst_n), .raw_n(btn_down_n),
    .stable_n(dn_cur_n), .stable_nxt_n(dn_nxt_n)
  );

  logic          set_press;
  logic          up_solo, dn_solo;
  logic          up_trig, dn_trig;
  logic          up_cont, dn_cont;
  logic          up_fire, dn_fire;
  logic          up_run,  dn_run;
  logic [HW-1:0] up_hold, dn_hold;
  logic [HW-1:0] up_hold_nxt, dn_hold_nxt;

  assign set_press = press_edge(set_cur_n, set_nxt_n);

  // Decisions use the post-edge stable levels so a release suppresses the
  // pulse on its own edge, and both-held blocks both channels at once.
  assign up_solo = (up_nxt_n == BTN_PRESSED) && (dn_nxt_n == BTN_RELEASED);
  assign dn_solo = (dn_nxt_n == BTN_PRESSED) && (up_nxt_n == BTN_RELEASED);

  assign up_trig = set_ena && up_solo &&
                   (press_edge(up_cur_n, up_nxt_n) ||
                    (release_edge(dn_cur_n, dn_nxt_n) && up_cur_n == BTN_PRESSED));
  assign dn_trig = set_ena && dn_solo &&
                   (press_edge(dn_cur_n, dn_nxt_n) ||
                    (release_edge(up_cur_n, up_nxt_n) && dn_cur_n == BTN_PRESSED));

  assign up_cont = set_ena && up_run && up_solo;
  assign dn_cont = set_ena && dn_run && dn_solo;

  assign up_fire = up_trig || (up_cont && up_hold == HOLD_LAST);
  assign dn_fire = dn_trig || (dn_cont && dn_hold == HOLD_LAST);

  always_comb begin
    up_hold_nxt = '0;
    if (!up_trig && up_cont) begin
      up_hold_nxt = (up_hold == HOLD_LAST) ? HOLD_RELOAD : up_hold + HW'(1);
    end
  end

  always_comb begin
    dn_hold_nxt = '0;
    if (!dn_trig && dn_cont) begin
      dn_hold_nxt = (dn_hold == HOLD_LAST) ? HOLD_RELOAD : dn_hold + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_ena <= 1'b0;
      up      <= 1'b1;
      down    <= 1'b1;
      up_run  <= 1'b0;
      dn_run  <= 1'b0;
      up_hold <= '0;
      dn_hold <= '0;
    end else begin
      set_ena <= set_ena ^ set_press;
      up      <= ~up_fire;
      down    <= ~dn_fire;
      up_run  <= up_trig | up_cont;
      dn_run  <= dn_trig | dn_cont;
      up_hold <= up_hold_nxt;
      dn_hold <= dn_hold_nxt;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 32;
  localparam int RP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_set_n = 1'b1;
  logic btn_up_n = 1'b1;
  logic btn_down_n = 1'b1;
  logic set_ena, up, down;

  button_conditioner #(.DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_set_n(btn_set_n), .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
    .set_ena(set_ena), .up(up), .down(down)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_up = 0;
  int n_dn = 0;
  bit chk_on = 0;

  // Reference model: raw history per channel (bit 0 = newest sample), stable
  // level, set mode, and per-direction "age since sole press" driving pulses.
  logic [DB+1:0] hist [3] = '{default: '1};
  logic m_stb [3] = '{default: 1'b1};
  logic m_set = 1'b0;
  logic m_out [2] = '{default: 1'b1};
  int   age [2] = '{default: 0};
  bit   act [2] = '{default: 1'b0};

  function automatic void model_reset();
    for (int ch = 0; ch < 3; ch++) begin
      hist[ch] = '1;
      m_stb[ch] = 1'b1;
    end
    m_set = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_out[c] = 1'b1;
      age[c] = 0;
      act[c] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    logic raw [3];
    logic nxt [3];
    bit pe [3];
    bit re [3];
    raw[0] = btn_set_n;
    raw[1] = btn_up_n;
    raw[2] = btn_down_n;
    for (int ch = 0; ch < 3; ch++) begin
      bit flip;
      hist[ch] = {hist[ch][DB:0], raw[ch]};
      // Synchronised value at this edge is the raw sample from 2 edges ago;
      // accept when the last DB synchronised samples all oppose the stable level.
      flip = 1'b1;
      for (int k = 2; k < DB + 2; k++)
        if (hist[ch][k] == m_stb[ch]) flip = 1'b0;
      pe[ch] = flip && m_stb[ch];
      re[ch] = flip && !m_stb[ch];
      nxt[ch] = flip ? ~m_stb[ch] : m_stb[ch];
    end
    for (int c = 0; c < 2; c++) begin
      int me;
      int oth;
      bit solo;
      bit trig;
      bit fire;
      me = c + 1;
      oth = 2 - c;
      solo = !nxt[me] && nxt[oth];
      trig = m_set && solo && (pe[me] || (re[oth] && !m_stb[me]));
      if (trig) begin
        act[c] = 1'b1;
        age[c] = 0;
      end else if (act[c] && m_set && solo) begin
        age[c] = age[c] + 1;
      end else begin
        act[c] = 1'b0;
        age[c] = 0;
      end
      fire = act[c] && (age[c] == 0 || (age[c] >= RD && (age[c] - RD) % RP == 0));
      m_out[c] = !fire;
    end
    if (pe[0]) m_set = !m_set;
    for (int ch = 0; ch < 3; ch++) m_stb[ch] = nxt[ch];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  task automatic check_bit(input string name, input logic act_v, input logic exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act_v, exp_v, $time);
    end
  endtask

  task automatic check_int(input string name, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act_v, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_on) begin
      check_bit("up_vs_model", up, m_out[0]);
      check_bit("down_vs_model", down, m_out[1]);
      check_bit("set_ena_vs_model", set_ena, m_set);
      checks++;
      if (!up && !down) begin
        failures++;
        $display("FAIL both_low: up=%b down=%b expected not both 0 at %0t", up, down, $time);
      end
    end
    if (!up) n_up++;
    if (!down) n_dn++;
  endtask

  task automatic drive(input int ch, input logic v);
    case (ch)
      0: btn_set_n = v;
      1: btn_up_n = v;
      default: btn_down_n = v;
    endcase
  endtask

  task automatic press(input int ch, input int n);
    drive(ch, 1'b0);
    repeat (n) tick();
    drive(ch, 1'b1);
  endtask

  typedef struct {
    int   btn;
    int   low;
    int   exp_up;
    int   exp_dn;
    logic exp_set;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int first;
    int rem [3];

    // btn: 0 SET, 1 UP, 2 DOWN; low = raw low cycles; expected pulse counts
    vecs[0]  = '{0, 10, 0, 0, 1'b1};
    vecs[1]  = '{1,  3, 0, 0, 1'b1};
    vecs[2]  = '{1,  4, 1, 0, 1'b1};
    vecs[3]  = '{1, 10, 1, 0, 1'b1};
    vecs[4]  = '{2, 60, 0, 5, 1'b1};
    vecs[5]  = '{1, 32, 1, 0, 1'b1};
    vecs[6]  = '{1, 33, 2, 0, 1'b1};
    vecs[7]  = '{2, 41, 0, 3, 1'b1};
    vecs[8]  = '{0, 10, 0, 0, 1'b0};
    vecs[9]  = '{1, 40, 0, 0, 1'b0};
    vecs[10] = '{2,  3, 0, 0, 1'b0};
    vecs[11] = '{0,  2, 0, 0, 1'b0};
    vecs[12] = '{0,  6, 0, 0, 1'b1};

    #20 rst_n = 1'b1;
    chk_on = 1'b1;

    // Idle after reset
    n_up = 0; n_dn = 0;
    repeat (50) tick();
    check_bit("idle_set_ena", set_ena, 1'b0);
    check_int("idle_up_pulses", n_up, 0);
    check_int("idle_down_pulses", n_dn, 0);

    // Table of single presses
    for (int i = 0; i < 13; i++) begin
      n_up = 0; n_dn = 0;
      press(vecs[i].btn, vecs[i].low);
      repeat (20) tick();
      check_int($sformatf("vec%0d_up_pulses", i), n_up, vecs[i].exp_up);
      check_int($sformatf("vec%0d_down_pulses", i), n_dn, vecs[i].exp_dn);
      check_bit($sformatf("vec%0d_set_ena", i), set_ena, vecs[i].exp_set);
    end

    // Bounce rejection: five 3-cycle glitches
    n_up = 0;
    repeat (5) begin
      press(1, 3);
      repeat (4) tick();
    end
    repeat (10) tick();
    check_int("bounce_up_pulses", n_up, 0);

    // Clean press latency: pulse seen after the 6th rising edge
    n_up = 0;
    first = -1;
    drive(1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (!up && first < 0) first = k;
    end
    drive(1, 1'b1);
    repeat (20) tick();
    check_int("clean_press_latency", first, 6);
    check_int("clean_press_pulses", n_up, 1);

    // UP and DOWN together, then release UP
    n_up = 0; n_dn = 0;
    drive(1, 1'b0);
    drive(2, 1'b0);
    repeat (20) tick();
    check_int("both_held_up_pulses", n_up, 0);
    check_int("both_held_down_pulses", n_dn, 0);
    drive(1, 1'b1);
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (!down) begin
        first = k;
        break;
      end
    end
    check_int("release_up_down_latency", first, 6);
    check_bit("pre_reset_set_ena", set_ena, 1'b1);

    // Asynchronous reset while DOWN is held and its pulse is on the output
    #2 rst_n = 1'b0;
    #1;
    check_bit("async_reset_down", down, 1'b1);
    check_bit("async_reset_up", up, 1'b1);
    check_bit("async_reset_set_ena", set_ena, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    n_dn = 0;
    repeat (20) tick();
    check_int("post_reset_held_down_pulses", n_dn, 0);
    drive(2, 1'b1);
    repeat (12) tick();

    // Randomised bouncing on all three buttons against the model
    for (int ch = 0; ch < 3; ch++) rem[ch] = 0;
    repeat (4000) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (rem[ch] == 0) begin
          drive(ch, 1'($urandom_range(0, 1)));
          rem[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 90) : $urandom_range(1, 6);
        end
        rem[ch]--;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
